// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the MAR/MDR memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mem_resp.sv
// Memory-side responder: single-word read/write from MAR/MDR to a synchronous
// SRAM with a fixed number of wait states; reads return on mdrin with rc.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 16,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_rd,
  input  logic          req_wr,
  input  logic [15:0]   mar,
  input  logic [DW-1:0] mdr,
  output logic [DW-1:0] mdrin,
  output logic          rc,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          sram_ce,
  output logic          sram_we,
  output logic          sram_oe
);

  state_t           state, state_d;
  op_t              op, op_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             accept;
  logic             finish;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      op         <= OP_RD;
      cnt        <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      mdrin      <= '0;
      rc         <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_d;
      op    <= op_d;
      cnt   <= cnt_d;
      if (accept) begin
        sram_addr  <= mar[AW-1:0];
        sram_wdata <= mdr;
      end
      if (finish && op == OP_RD) begin
        mdrin <= sram_rdata;
      end
      // rc/done are set on the last ACCESS edge, so they cover exactly the DONE cycle.
      rc   <= finish && (op == OP_RD);
      done <= finish;
    end
  end

  always_comb begin
    state_d = state;
    op_d    = op;
    cnt_d   = cnt;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_wr || req_rd) begin
          accept  = 1'b1;
          op_d    = req_wr ? OP_WR : OP_RD;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt == '0) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign sram_ce = (state == S_ACCESS);
  assign sram_oe = sram_ce && (op == OP_RD);
  assign sram_we = sram_ce && (op == OP_WR);

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: vector table plus scoreboard on a WAIT_CYCLES=2 instance,
// hand sequences for busy-time requests, reset abort and a WAIT_CYCLES=0 instance.
module tb_mem_resp;

  localparam int unsigned W = 2;

  logic        clk, rstn;
  logic        req_rd, req_wr, rc, done, busy, sram_ce, sram_we, sram_oe;
  logic [15:0] mar, mdr, mdrin, sram_addr, sram_wdata, sram_rdata;
  logic        req_rd0, req_wr0, rc0, done0, busy0, sram_ce0, sram_we0, sram_oe0;
  logic [15:0] mar0, mdr0, mdrin0, sram_addr0, sram_wdata0, sram_rdata0;

  logic [15:0] mem  [0:65535];
  logic [15:0] mem0 [0:65535];

  assign sram_rdata  = mem[sram_addr];
  assign sram_rdata0 = mem0[sram_addr0];

  mem_resp #(.AW(16), .DW(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rstn(rstn), .req_rd(req_rd), .req_wr(req_wr), .mar(mar), .mdr(mdr),
    .mdrin(mdrin), .rc(rc), .done(done), .busy(busy), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ce(sram_ce),
    .sram_we(sram_we), .sram_oe(sram_oe)
  );

  mem_resp #(.AW(16), .DW(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn), .req_rd(req_rd0), .req_wr(req_wr0), .mar(mar0), .mdr(mdr0),
    .mdrin(mdrin0), .rc(rc0), .done(done0), .busy(busy0), .sram_addr(sram_addr0),
    .sram_wdata(sram_wdata0), .sram_rdata(sram_rdata0), .sram_ce(sram_ce0),
    .sram_we(sram_we0), .sram_oe(sram_oe0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic        rd, wr;
    logic [15:0] addr, wdata;
    logic        pre;
    logic [15:0] pre_val;
    logic        exp_rd;
    logic [15:0] exp_data;
  } vec_t;

  exp_t        sb_q[$];
  int          done_cyc[$];
  int          cyc;
  int          npass, ntotal;
  logic [15:0] exp_mdrin;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn) begin
        if (rc) check("rc_implies_done", done, 1);
        if (done) begin
          done_cyc.push_back(cyc);
          check("sb_expected_done", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_rc", rc, e.is_rd);
            if (e.is_rd) exp_mdrin = e.data;
            check("sb_mdrin", mdrin, exp_mdrin);
          end
        end
      end
    end
  endtask

  task automatic sram_model();
    forever begin
      @(posedge clk);
      if (sram_ce && sram_we) mem[sram_addr] = sram_wdata;
      if (sram_ce0 && sram_we0) mem0[sram_addr0] = sram_wdata0;
    end
  endtask

  // Full access on the W=2 instance with cycle-exact strobe checks.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic exp_rd,
                           input logic [15:0] exp_data);
    exp_t e;
    @(negedge clk);
    req_rd = rd; req_wr = wr; mar = addr; mdr = wdata;
    e.is_rd = exp_rd; e.data = exp_data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_rd = 1'b0; req_wr = 1'b0;
    mar = 16'($urandom); mdr = 16'($urandom);
    for (int unsigned k = 0; k <= W; k++) begin
      @(negedge clk);
      check("acc_busy", busy, 1);
      check("acc_ce", sram_ce, 1);
      check("acc_oe", sram_oe, exp_rd);
      check("acc_we", sram_we, !exp_rd);
      check("acc_addr", sram_addr, addr);
      check("acc_wdata", sram_wdata, wdata);
      check("acc_no_done", done, 0);
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_rc", rc, exp_rd);
    check("done_ce_off", {sram_ce, sram_we, sram_oe}, 0);
    check("done_busy", busy, 1);
    @(negedge clk);
    check("idle_strobes", {busy, rc, done}, 0);
  endtask

  initial begin
    int n0;
    exp_t e;
    npass = 0; ntotal = 0; cyc = 0; exp_mdrin = '0;
    rstn = 1'b0;
    req_rd = 1'b0; req_wr = 1'b0; mar = '0; mdr = '0;
    req_rd0 = 1'b0; req_wr0 = 1'b0; mar0 = '0; mdr0 = '0;
    fork
      monitor();
      sram_model();
    join_none

    vecs[0] = '{1'b1, 1'b0, 16'h0123, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 16'h0040, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 16'h0010, 16'h00AA, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1234};
    vecs[4] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h00AA};
    vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h8001, 1'b1, 16'h8001};
    vecs[6] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5C3, 1'b1, 16'hA5C3};

    // Reset with random activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      req_rd = 1'($urandom); req_wr = 1'($urandom); mar = 16'($urandom); mdr = 16'($urandom);
      @(negedge clk);
      check("rst_outputs", {mdrin, rc, done, busy, sram_addr, sram_wdata,
                            sram_ce, sram_we, sram_oe}, 0);
    end
    req_rd = 1'b0; req_wr = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_release_busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre) mem[vecs[i].addr] = vecs[i].pre_val;
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rd, vecs[i].exp_data);
      if (!vecs[i].exp_rd) check("sram_written", mem[vecs[i].addr], vecs[i].wdata);
    end

    // Write pulse while busy is dropped; a read held through DONE is taken
    // at the first IDLE edge.
    mem[16'h0200] = 16'h1111; mem[16'h0201] = 16'h2222; mem[16'h0300] = 16'h0000;
    n0 = done_cyc.size();
    @(negedge clk);
    req_rd = 1'b1; mar = 16'h0200;
    e.is_rd = 1'b1; e.data = 16'h1111; sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_rd = 1'b0;
    @(negedge clk);
    req_wr = 1'b1; mar = 16'h0300; mdr = 16'hDEAD;
    @(negedge clk);
    req_wr = 1'b0; req_rd = 1'b1; mar = 16'h0201;
    e.is_rd = 1'b1; e.data = 16'h2222; sb_q.push_back(e);
    repeat (4) @(negedge clk);
    check("held_rd_accepted", {busy, sram_oe, sram_addr}, {1'b1, 1'b1, 16'h0201});
    req_rd = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_wr_ignored", mem[16'h0300], 16'h0000);
    check("held_done_count", done_cyc.size() - n0, 2);
    if (done_cyc.size() - n0 == 2)
      check("held_done_spacing", done_cyc[n0+1] - done_cyc[n0], W + 3);

    // WAIT_CYCLES=0 instance: single ACCESS cycle.
    mem0[16'h0077] = 16'h5A5A;
    @(negedge clk);
    req_rd0 = 1'b1; mar0 = 16'h0077;
    @(posedge clk);
    #1;
    req_rd0 = 1'b0; mar0 = 16'($urandom);
    @(negedge clk);
    check("w0_access", {busy0, sram_ce0, sram_oe0, sram_we0, rc0, done0},
          6'b111000);
    check("w0_addr", sram_addr0, 16'h0077);
    @(negedge clk);
    check("w0_done", {rc0, done0, sram_ce0}, 3'b110);
    check("w0_mdrin", mdrin0, 16'h5A5A);
    @(negedge clk);
    check("w0_idle", {busy0, rc0, done0}, 0);
    check("w0_mdrin_hold", mdrin0, 16'h5A5A);

    // Reset lands mid-ACCESS: aborted read produces no rc/done.
    n0 = done_cyc.size();
    @(negedge clk);
    req_rd = 1'b1; mar = 16'h0123;
    @(posedge clk);
    #1;
    req_rd = 1'b0;
    @(negedge clk);
    #2;
    rstn = 1'b0;
    req_rd = 1'($urandom); req_wr = 1'($urandom); mar = 16'($urandom);
    #1;
    check("midrst_outputs", {mdrin, rc, done, busy, sram_addr, sram_wdata,
                             sram_ce, sram_we, sram_oe}, 0);
    check("midrst_mdrin0", mdrin0, 0);
    sb_q.delete();
    exp_mdrin = '0;
    @(posedge clk);
    req_rd = 1'b0; req_wr = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_release", {busy, rc, done, mdrin}, 0);
    check("midrst_no_done", done_cyc.size() - n0, 0);
    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h1234);

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
